regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 128 ++++++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Scoreboarded register file: flop-based storage with two prioritised write ports,
// combinational bypassed reads, per-register pending bits and a registered debug tap.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [AW-1:0]       tap_addr,
    output logic [XLEN-1:0]     tap_data,
    output logic [XLEN-1:0]     a0,
    output logic [AW:0]         busy_cnt,
    output logic                wr_collide
);

    // Lookup slots: the read ports, then the debug tap, then the a0 view.
    localparam int NL = NRP + 2;
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]         regs_q [NREGS];
    logic [XLEN-1:0]         regs_d [NREGS];
    logic [NREGS-1:0]        busy_q, busy_d;
    logic                    wr_collide_q, wr_collide_d;
    logic [XLEN-1:0]         tap_data_q, tap_data_d;

    logic                    wa_ok, wb_ok, iss_ok, collide;
    logic [NL-1:0][AW-1:0]   lk_addr;
    logic [NL-1:0][XLEN-1:0] lk_data;
    logic [NL-1:0]           lk_busy;
    logic [AW:0]             cnt;

    // Address 0 and out-of-range addresses are inert for writes and issues.
    assign wa_ok   = wa_en  && (wa_addr  != '0) && ({1'b0, wa_addr}  < NREGS_W);
    assign wb_ok   = wb_en  && (wb_addr  != '0) && ({1'b0, wb_addr}  < NREGS_W);
    assign iss_ok  = iss_en && (iss_addr != '0) && ({1'b0, iss_addr} < NREGS_W);
    assign collide = wa_ok && wb_ok && (wa_addr == wb_addr);

    generate
        for (genvar gi = 0; gi < NRP; gi++) begin : g_port
            assign lk_addr[gi]                = rd_addr[gi*AW +: AW];
            assign rd_data[gi*XLEN +: XLEN]   = lk_data[gi];
            assign rd_busy[gi]                = lk_busy[gi];
        end
    endgenerate

    // With 10 or fewer registers a0 points at address 0, which always reads zero.
    assign lk_addr[NRP]     = tap_addr;
    assign lk_addr[NRP + 1] = (NREGS > 10) ? AW'(10) : '0;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lookup
            logic valid, hit_a, hit_b;
            assign valid = (lk_addr[gi] != '0) && ({1'b0, lk_addr[gi]} < NREGS_W);
            assign hit_a = wa_ok && (wa_addr == lk_addr[gi]);
            assign hit_b = wb_ok && (wb_addr == lk_addr[gi]);
            // Bypass is independent of rst so write data is visible even in a reset cycle.
            assign lk_data[gi] = !valid ? '0 :
                                 hit_a  ? wa_data :
                                 hit_b  ? wb_data : regs_q[lk_addr[gi]];
            assign lk_busy[gi] = valid && busy_q[lk_addr[gi]] && !(hit_a || hit_b);
        end
    endgenerate

    assign a0 = lk_data[NRP + 1];

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + (AW+1)'(busy_q[i]);
        end
    end

    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        wr_collide_d = wr_collide_q | collide;
        tap_data_d   = lk_data[NRP];
        for (int i = 1; i < NREGS; i++) begin
            // B first so that A overrides it on a shared address.
            if (wb_ok && (wb_addr == AW'(i))) begin
                regs_d[i] = wb_data;
                busy_d[i] = 1'b0;
            end
            if (wa_ok && (wa_addr == AW'(i))) begin
                regs_d[i] = wa_data;
                busy_d[i] = 1'b0;
            end
            if (iss_ok && (iss_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
            busy_d       = '0;
            wr_collide_d = 1'b0;
            tap_data_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q       <= regs_d;
        busy_q       <= busy_d;
        wr_collide_q <= wr_collide_d;
        tap_data_q   <= tap_data_d;
    end

    assign tap_data   = tap_data_q;
    assign busy_cnt   = cnt;
    assign wr_collide = wr_collide_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRP = 2;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wa_en, wb_en, iss_en;
    logic [AW-1:0]       wa_addr, wb_addr, iss_addr, tap_addr;
    logic [XLEN-1:0]     wa_data, wb_data, tap_data, a0;
    logic [AW:0]         busy_cnt;
    logic                wr_collide;

    int total = 0;
    int bad = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] e;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .tap_addr(tap_addr), .tap_data(tap_data),
        .a0(a0), .busy_cnt(busy_cnt), .wr_collide(wr_collide)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic idle();
        wa_en = 0; wb_en = 0; iss_en = 0;
        wa_addr = 0; wb_addr = 0; iss_addr = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); rd_addr = 0; tap_addr = 0;
        tick();
        tick();
        rst = 0;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(busy_cnt) !== e) begin bad++; $display("FAIL reset_busy_cnt got=%0d exp=%0d", busy_cnt, e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(wr_collide) !== e) begin bad++; $display("FAIL reset_collide got=%0d exp=%0d", wr_collide, e); end
        e = exp_q.pop_front(); total++;
        if (tap_data !== e) begin bad++; $display("FAIL reset_tap got=%h exp=%h", tap_data, e); end
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(NREGS - 1 - a), AW'(a)};
            exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
            #1;
            e = exp_q.pop_front(); total++;
            if (rd_data[31:0] !== e) begin bad++; $display("FAIL reset_rd0 a=%0d got=%h exp=%h", a, rd_data[31:0], e); end
            e = exp_q.pop_front(); total++;
            if (rd_data[63:32] !== e) begin bad++; $display("FAIL reset_rd1 a=%0d got=%h exp=%h", a, rd_data[63:32], e); end
            e = exp_q.pop_front(); total++;
            if (XLEN'(rd_busy) !== e) begin bad++; $display("FAIL reset_busy a=%0d got=%b exp=0", a, rd_busy); end
        end
        $display("txn reset done");
    endtask

    task automatic test_bypass();
        idle();
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd_addr = {AW'(5), AW'(5)};
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL bypass_rd0 got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); total++;
        if (rd_data[63:32] !== e) begin bad++; $display("FAIL bypass_rd1 got=%h exp=%h", rd_data[63:32], e); end
        tick();
        idle();
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL stored_rd0 got=%h exp=%h", rd_data[31:0], e); end
        $display("txn bypass addr=5 data=%h", rd_data[31:0]);
    endtask

    task automatic test_collide();
        idle();
        wa_en = 1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 7; wb_data = 32'h22;
        rd_addr = {AW'(7), AW'(7)};
        exp_q.push_back(32'h11);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL collide_bypass got=%h exp=%h", rd_data[31:0], e); end
        tick();
        idle();
        exp_q.push_back(32'h11); exp_q.push_back(1);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL collide_store got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(wr_collide) !== e) begin bad++; $display("FAIL collide_flag got=%0d exp=%0d", wr_collide, e); end
        // Dual write to distinct addresses, both commit; flag stays sticky.
        wa_en = 1; wa_addr = 12; wa_data = 32'hA0A0;
        wb_en = 1; wb_addr = 13; wb_data = 32'hB0B0;
        tick();
        idle();
        rd_addr = {AW'(13), AW'(12)};
        exp_q.push_back(32'hA0A0); exp_q.push_back(32'hB0B0); exp_q.push_back(1);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL dual_a got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); total++;
        if (rd_data[63:32] !== e) begin bad++; $display("FAIL dual_b got=%h exp=%h", rd_data[63:32], e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(wr_collide) !== e) begin bad++; $display("FAIL collide_sticky got=%0d exp=%0d", wr_collide, e); end
        $display("txn collide flag=%0d", wr_collide);
    endtask

    task automatic test_busy();
        idle();
        iss_en = 1; iss_addr = 3; rd_addr = {AW'(3), AW'(3)};
        exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(rd_busy[0]) !== e) begin bad++; $display("FAIL iss_same_cycle got=%0d exp=%0d", rd_busy[0], e); end
        tick();
        idle();
        exp_q.push_back(1); exp_q.push_back(1);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(rd_busy[0]) !== e) begin bad++; $display("FAIL iss_busy got=%0d exp=%0d", rd_busy[0], e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(busy_cnt) !== e) begin bad++; $display("FAIL iss_cnt got=%0d exp=%0d", busy_cnt, e); end
        wb_en = 1; wb_addr = 3; wb_data = 32'h55;
        exp_q.push_back(0); exp_q.push_back(32'h55);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(rd_busy[0]) !== e) begin bad++; $display("FAIL wb_clear_busy got=%0d exp=%0d", rd_busy[0], e); end
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL wb_bypass got=%h exp=%h", rd_data[31:0], e); end
        tick();
        idle();
        exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(busy_cnt) !== e) begin bad++; $display("FAIL wb_cnt got=%0d exp=%0d", busy_cnt, e); end
        // Issue and write to the same register in one cycle: issue wins.
        iss_en = 1; iss_addr = 4; wa_en = 1; wa_addr = 4; wa_data = 32'h44;
        tick();
        idle();
        rd_addr = {AW'(4), AW'(4)};
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(32'h44);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(rd_busy[1]) !== e) begin bad++; $display("FAIL iss_wins_busy got=%0d exp=%0d", rd_busy[1], e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(busy_cnt) !== e) begin bad++; $display("FAIL iss_wins_cnt got=%0d exp=%0d", busy_cnt, e); end
        e = exp_q.pop_front(); total++;
        if (rd_data[63:32] !== e) begin bad++; $display("FAIL iss_wins_data got=%h exp=%h", rd_data[63:32], e); end
        wa_en = 1; wa_addr = 4; wa_data = 32'h45;
        tick();
        idle();
        exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (XLEN'(busy_cnt) !== e) begin bad++; $display("FAIL busy_drain got=%0d exp=%0d", busy_cnt, e); end
        $display("txn busy cnt=%0d", busy_cnt);
    endtask

    task automatic test_zero_tap();
        idle();
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF; iss_en = 1; iss_addr = 0;
        rd_addr = {AW'(0), AW'(0)};
        exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL zero_bypass got=%h exp=%h", rd_data[31:0], e); end
        tick();
        idle();
        exp_q.push_back(0); exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL zero_store got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(busy_cnt) !== e) begin bad++; $display("FAIL zero_cnt got=%0d exp=%0d", busy_cnt, e); end
        wa_en = 1; wa_addr = 10; wa_data = 32'h1234;
        exp_q.push_back(32'h1234);
        #1;
        e = exp_q.pop_front(); total++;
        if (a0 !== e) begin bad++; $display("FAIL a0_bypass got=%h exp=%h", a0, e); end
        tick();
        idle();
        tap_addr = 10;
        tick();
        exp_q.push_back(32'h1234); exp_q.push_back(32'h1234);
        e = exp_q.pop_front(); total++;
        if (tap_data !== e) begin bad++; $display("FAIL tap got=%h exp=%h", tap_data, e); end
        e = exp_q.pop_front(); total++;
        if (a0 !== e) begin bad++; $display("FAIL a0_store got=%h exp=%h", a0, e); end
        $display("txn tap addr=10 data=%h", tap_data);
    endtask

    task automatic test_reset_write();
        idle();
        rst = 1; wa_en = 1; wa_addr = 9; wa_data = 32'h99; rd_addr = {AW'(5), AW'(9)};
        exp_q.push_back(32'h99);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL rst_bypass got=%h exp=%h", rd_data[31:0], e); end
        tick();
        rst = 0; idle();
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); total++;
        if (rd_data[31:0] !== e) begin bad++; $display("FAIL rst_addr9 got=%h exp=%h", rd_data[31:0], e); end
        e = exp_q.pop_front(); total++;
        if (rd_data[63:32] !== e) begin bad++; $display("FAIL rst_addr5 got=%h exp=%h", rd_data[63:32], e); end
        e = exp_q.pop_front(); total++;
        if (tap_data !== e) begin bad++; $display("FAIL rst_tap got=%h exp=%h", tap_data, e); end
        e = exp_q.pop_front(); total++;
        if (XLEN'(wr_collide) !== e) begin bad++; $display("FAIL rst_collide got=%0d exp=%0d", wr_collide, e); end
        $display("txn reset_write addr9=%h", rd_data[31:0]);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collide();
        test_busy();
        test_zero_tap();
        test_reset_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
